// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-master SPI RAM arbiter.
package spi_arb_pkg;

    localparam int   DATA_W = 32;
    localparam logic M0     = 1'b0;
    localparam logic M1     = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } arb_state_e;

    // Round-robin choice: a lone request wins, contention goes to the master not served last.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        logic pick;
        if (req0 && req1) begin
            pick = ~last;
        end else if (req1) begin
            pick = M1;
        end else begin
            pick = M0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Saturating busy-wait counter; flags expiry on the cycle its count reaches TIMEOUT.
module arb_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles, holding at TIMEOUT instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (en && (r_count < CNT_W'(TIMEOUT))) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // This enabled cycle is the one that brings the count up to TIMEOUT.
    assign expired = en && (r_count >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter sharing one SPI RAM port between the CPU (m0) and a secondary master (m1).
module spi_ram_arbiter
    import spi_arb_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_word_address,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_rd,
    output logic              ram_wr,
    input  logic              ram_rbusy,
    input  logic              ram_wbusy,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              grant
);
    arb_state_e        r_state;
    logic              r_last_grant;
    logic              r_grant;
    logic              r_wr;
    logic              r_ram_rd;
    logic              r_ram_wr;
    logic              r_m0_ack;
    logic              r_m1_ack;
    logic              r_m0_err;
    logic              r_m1_err;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_addr;

    logic w_pick;
    logic w_busy;
    logic w_wd_clear;
    logic w_wd_en;
    logic w_wd_expired;

    assign w_pick     = rr_pick(m0_req, m1_req, r_last_grant);
    assign w_busy     = r_wr ? ram_wbusy : ram_rbusy;
    assign w_wd_clear = (r_state == ISSUE);
    assign w_wd_en    = (r_state == WAIT);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_wd_clear),
        .en      (w_wd_en),
        .expired (w_wd_expired)
    );

    // Transaction sequencer: grant, strobe, settle, poll busy, acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= M1;
            r_grant      <= M0;
            r_wr         <= 1'b0;
            r_ram_rd     <= 1'b0;
            r_ram_wr     <= 1'b0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_err     <= 1'b0;
            r_m1_err     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_wdata      <= '0;
            r_addr       <= '0;
        end else begin
            r_ram_rd <= 1'b0;
            r_ram_wr <= 1'b0;
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            r_m0_err <= 1'b0;
            r_m1_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        r_grant  <= w_pick;
                        r_wr     <= (w_pick == M1) ? m1_wr : m0_wr;
                        r_addr   <= (w_pick == M1) ? m1_addr : m0_addr;
                        r_wdata  <= (w_pick == M1) ? m1_wdata : m0_wdata;
                        r_ram_rd <= (w_pick == M1) ? ~m1_wr : ~m0_wr;
                        r_ram_wr <= (w_pick == M1) ? m1_wr : m0_wr;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= SETTLE;
                end
                // Busy is registered inside the RAM, so it is only meaningful from here on.
                SETTLE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (!w_busy) begin
                        if (!r_wr && (r_grant == M1)) begin
                            r_m1_rdata <= ram_rdata;
                        end else if (!r_wr) begin
                            r_m0_rdata <= ram_rdata;
                        end
                        r_m0_ack <= (r_grant == M0);
                        r_m1_ack <= (r_grant == M1);
                        r_state  <= DONE;
                    end else if (w_wd_expired) begin
                        r_m0_ack <= (r_grant == M0);
                        r_m1_ack <= (r_grant == M1);
                        r_m0_err <= (r_grant == M0);
                        r_m1_err <= (r_grant == M1);
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_last_grant <= r_grant;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m0_ack           = r_m0_ack;
    assign m0_err           = r_m0_err;
    assign m0_rdata         = r_m0_rdata;
    assign m1_ack           = r_m1_ack;
    assign m1_err           = r_m1_err;
    assign m1_rdata         = r_m1_rdata;
    assign ram_word_address = r_addr;
    assign ram_wdata        = r_wdata;
    assign ram_rd           = r_ram_rd;
    assign ram_wr           = r_ram_wr;
    assign grant            = r_grant;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed scoreboard bench for spi_ram_arbiter with a registered-busy SPI RAM model.
module tb_spi_ram_arbiter;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
        logic [19:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
    logic [19:0] m0_addr = 20'd0, m1_addr = 20'd0;
    logic [31:0] m0_wdata = 32'd0, m1_wdata = 32'd0;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [19:0] ram_word_address;
    logic [31:0] ram_wdata;
    logic        ram_rd, ram_wr, ram_rbusy, ram_wbusy, grant;
    logic [31:0] ram_rdata = 32'd0;

    int          busy_len = 1;
    logic        stuck = 1'b0;
    int          bcnt = 0;
    logic        pend_wr = 1'b0;
    logic [19:0] last_wa = 20'd0;
    logic [31:0] last_wd = 32'd0;

    int          total = 0, bad = 0;
    int          rd_cnt = 0, wr_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
    logic [31:0] trk0 = 32'd0, trk1 = 32'd0;
    exp_t        sb[$];

    spi_ram_arbiter #(.ADDR_W(20), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .ram_word_address(ram_word_address), .ram_wdata(ram_wdata),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_rbusy(ram_rbusy), .ram_wbusy(ram_wbusy),
        .ram_rdata(ram_rdata), .grant(grant)
    );

    always #5 clk = ~clk;

    // RAM model: busy rises the cycle after a strobe and stays high busy_len cycles.
    always @(posedge clk) begin
        if (reset) begin
            bcnt    <= 0;
            pend_wr <= 1'b0;
        end else if (ram_rd || ram_wr) begin
            bcnt    <= busy_len;
            pend_wr <= ram_wr;
            if (ram_wr) begin
                last_wa <= ram_word_address;
                last_wd <= ram_wdata;
            end
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
        end
    end

    assign ram_rbusy = !pend_wr && (bcnt != 0);
    assign ram_wbusy = stuck || (pend_wr && (bcnt != 0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One cycle: sample at negedge, tally strobes/acks, check the per-cycle invariants.
    task automatic tick();
        @(negedge clk);
        if (ram_rd === 1'b1) rd_cnt++;
        if (ram_wr === 1'b1) wr_cnt++;
        if (m0_ack === 1'b1) ack0_cnt++;
        if (m1_ack === 1'b1) ack1_cnt++;
        chk("strobe_excl", {31'd0, ram_rd & ram_wr}, 32'd0);
        chk("ack_excl", {31'd0, m0_ack & m1_ack}, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack_err"}, {28'd0, m0_ack, m1_ack, m0_err, m1_err}, 32'd0);
        chk({tag, "_strb_gnt"}, {29'd0, ram_rd, ram_wr, grant}, 32'd0);
        chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
        chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
        chk({tag, "_addr"}, {12'd0, ram_word_address}, 32'd0);
        chk({tag, "_wdata"}, ram_wdata, 32'd0);
    endtask

    task automatic expect_txn(input logic p, input logic wr, input logic [19:0] a, input logic err);
        exp_t e;
        if (!wr && !err) begin
            if (p) trk1 = ram_rdata;
            else   trk0 = ram_rdata;
        end
        e.port  = p;
        e.err   = err;
        e.addr  = a;
        e.rdata = p ? trk1 : trk0;
        sb.push_back(e);
    endtask

    task automatic drive(input logic p, input logic wr, input logic [19:0] a, input logic [31:0] d);
        if (p) begin
            m1_req = 1'b1; m1_wr = wr; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = 1'b1; m0_wr = wr; m0_addr = a; m0_wdata = d;
        end
    endtask

    task automatic start(input logic p, input logic wr, input logic [19:0] a, input logic [31:0] d,
                         input logic err);
        expect_txn(p, wr, a, err);
        drive(p, wr, a, d);
    endtask

    // Wait for the next ack, pop its expectation and compare; lat counts cycles waited.
    task automatic wait_ack(input int budget, input logic drop, output int lat);
        exp_t e;
        logic p;
        logic seen;
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= budget && !seen; n++) begin
            tick();
            if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        chk("ack_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            p = m1_ack;
            chk("sb_level", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ack_port", {31'd0, p}, {31'd0, e.port});
                chk("grant", {31'd0, grant}, {31'd0, e.port});
                chk("err", {31'd0, p ? m1_err : m0_err}, {31'd0, e.err});
                chk("rdata", p ? m1_rdata : m0_rdata, e.rdata);
                chk("addr_held", {12'd0, ram_word_address}, {12'd0, e.addr});
            end
            if (drop && p) m1_req = 1'b0;
            if (drop && !p) m0_req = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat, r0, w0, a0, a1;

        // reset state
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();

        // single read, busy for 5 cycles
        busy_len = 5; ram_rdata = 32'hDEADBEEF;
        r0 = rd_cnt; w0 = wr_cnt;
        start(1'b0, 1'b0, 20'h00010, 32'd0, 1'b0);
        wait_ack(40, 1'b1, lat);
        chk("rd_lat", lat, 32'd8);
        tick();
        chk("rd_pulses", rd_cnt - r0, 32'd1);
        chk("rd_no_wr", wr_cnt - w0, 32'd0);
        chk("rdata_hold", m0_rdata, 32'hDEADBEEF);

        // minimum latency read on m1
        busy_len = 1; ram_rdata = 32'h0BADF00D;
        start(1'b1, 1'b0, 20'h00ABC, 32'd0, 1'b0);
        wait_ack(40, 1'b1, lat);
        chk("min_lat", lat, 32'd4);
        tick();

        // contention straight out of reset: m0 write wins, then m1 read
        reset = 1'b1; tick(); tick(); reset = 1'b0; trk0 = 32'd0; trk1 = 32'd0; tick();
        busy_len = 2; ram_rdata = 32'h11112222;
        start(1'b0, 1'b1, 20'h00004, 32'h12345678, 1'b0);
        start(1'b1, 1'b0, 20'h00008, 32'd0, 1'b0);
        wait_ack(40, 1'b1, lat);
        chk("cont_lat0", lat, 32'd5);
        chk("cont_wr_addr", {12'd0, last_wa}, 32'h00000004);
        chk("cont_wr_data", last_wd, 32'h12345678);
        wait_ack(40, 1'b1, lat);
        chk("cont_lat1", lat, 32'd6);
        tick();

        // both held continuously: grants alternate 0,1,0,1
        busy_len = 1; ram_rdata = 32'h600DD00D;
        for (int i = 0; i < 4; i++) expect_txn(i[0], ~i[0], i[0] ? 20'h00034 : 20'h00030, 1'b0);
        drive(1'b0, 1'b1, 20'h00030, 32'hA5A5A5A5);
        drive(1'b1, 1'b0, 20'h00034, 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_ack(40, 1'b0, lat);
            chk("alt_lat", lat, (i == 0) ? 32'd4 : 32'd5);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();

        // m1 drops its request one cycle after being granted
        busy_len = 3; ram_rdata = 32'h55AA1234;
        r0 = rd_cnt; a1 = ack1_cnt;
        start(1'b1, 1'b0, 20'h00040, 32'd0, 1'b0);
        tick();
        m1_req = 1'b0;
        wait_ack(40, 1'b1, lat);
        chk("drop_lat", lat, 32'd5);
        repeat (6) tick();
        chk("drop_rd_pulses", rd_cnt - r0, 32'd1);
        chk("drop_acks", ack1_cnt - a1, 32'd1);

        // watchdog abort on a stuck write, then a normal read
        stuck = 1'b1;
        start(1'b1, 1'b1, 20'h00044, 32'hCAFEF00D, 1'b1);
        wait_ack(60, 1'b1, lat);
        chk("to_lat", lat, 32'd18);
        stuck = 1'b0;
        tick();
        busy_len = 2; ram_rdata = 32'h77778888;
        start(1'b0, 1'b0, 20'h00048, 32'd0, 1'b0);
        wait_ack(40, 1'b1, lat);
        chk("post_to_lat", lat, 32'd5);
        tick();

        // reset during WAIT of a long read
        busy_len = 10; ram_rdata = 32'h99990000;
        a0 = ack0_cnt;
        start(1'b0, 1'b0, 20'h00050, 32'd0, 1'b0);
        repeat (4) tick();
        reset = 1'b1; m0_req = 1'b0;
        sb.delete();
        tick();
        chk_zero("midwait");
        reset = 1'b0; trk0 = 32'd0; trk1 = 32'd0;
        repeat (12) tick();
        chk("midwait_no_ack", ack0_cnt - a0, 32'd0);
        busy_len = 1; ram_rdata = 32'h0A0B0C0D;
        start(1'b0, 1'b0, 20'h00054, 32'd0, 1'b0);
        wait_ack(40, 1'b1, lat);
        chk("after_rst_lat", lat, 32'd4);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
